// File: rtl/prm_sched_pkg.sv
// Shared definitions for the PRM edge-checker scheduler.
// Holds the scheduler state type, the default obstacle-code width and a
// ceiling-division helper that sizes the result word stream.
package prm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } schedState_e;

  localparam int CODE_W_DEF = 15;

  // Ceiling division, used to get the number of OUT_W words covering all edges
  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/prm_mask_accum.sv
// OR accumulator for the per-edge collision masks of one frame.
// The accumulator is padded up to a whole number of output words, with the
// padding treated as permanently blocked, and a word-sized slice of the
// edge-free bitmap (~collision) is selected by the word index.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clear the accumulator (has priority over load_i)
//   load_i    : OR mask_i into the accumulator
//   mask_i    : collision mask from the checker array
//   idx_i     : output word index
//   free_o    : edge-free bits of word idx_i, padding bits read 0
module prm_mask_accum
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGE = 512,
  parameter int OUT_W    = 32,
  parameter int NWORD    = cdiv(NUM_EDGE, OUT_W),
  parameter int IDX_W    = (NWORD > 1) ? $clog2(NWORD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [NUM_EDGE-1:0] mask_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [OUT_W-1:0]    free_o
);

  logic [NUM_EDGE-1:0]    acc_q;
  logic [NWORD*OUT_W-1:0] padded;

  // Collision bits only ever get set during a frame; a clear wipes the
  // whole frame so the next one starts from an all-free map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= acc_q | mask_i;
    end
  end

  // Padding positions above NUM_EDGE are marked as colliding, so after
  // inversion they never report a free edge to the planner.
  always_comb begin
    padded                 = '1;
    padded[NUM_EDGE-1:0]   = acc_q;
  end

  assign free_o = ~padded[int'(idx_i)*OUT_W +: OUT_W];

endmodule

// File: rtl/prm_edge_chk_sched.sv
// Time-multiplexes the PRM obstacle-logic checker array over a frame of
// obstacle voxel codes. Each accepted code is registered onto chk_code, the
// checker array settles for CHK_LAT cycles, and its collision mask is ORed
// into a frame accumulator. After the last code of a frame the edge-free
// bitmap is streamed to the planner in OUT_W-bit words.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous frame abort
//   obs_valid/ready     : obstacle code handshake (obs_code, obs_last)
//   chk_code / chk_mask : code to the checker array / its collision mask
//   res_valid/ready     : result word handshake (res_data, res_idx, res_last)
//   obs_cnt             : codes accumulated this frame, saturating
//   busy                : scheduler not idle
module prm_edge_chk_sched
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGE = 512,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int CHK_LAT  = 1,
  parameter int OUT_W    = 32,
  localparam int NWORD   = cdiv(NUM_EDGE, OUT_W),
  localparam int IDX_W   = (NWORD > 1) ? $clog2(NWORD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                obs_valid,
  output logic                obs_ready,
  input  logic [CODE_W-1:0]   obs_code,
  input  logic                obs_last,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUT_W-1:0]    res_data,
  output logic [IDX_W-1:0]    res_idx,
  output logic                res_last,
  output logic [15:0]         obs_cnt,
  output logic                busy
);

  schedState_e       state_q;
  logic [CODE_W-1:0] chkCode_q;
  logic              last_q;
  logic [3:0]        wCnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [15:0]       obsCnt_q;
  logic [15:0]       obsCnt_d;
  logic              obsFire;
  logic              resFire;
  logic              sampleNow;
  logic              lastWord;

  // A code is never taken while the frame is being aborted or reset.
  assign obs_ready = (state_q == IDLE) && !flush && !rst;
  assign obsFire   = obs_valid && obs_ready;
  assign res_valid = (state_q == DRAIN);
  assign resFire   = res_valid && res_ready;
  assign sampleNow = (state_q == WAIT) && (wCnt_q == 4'd0);
  assign lastWord  = (idx_q == IDX_W'(NWORD - 1));
  assign obsCnt_d  = (obsCnt_q == 16'hFFFF) ? obsCnt_q : obsCnt_q + 16'd1;

  assign chk_code = chkCode_q;
  assign res_idx  = idx_q;
  assign res_last = res_valid && lastWord;
  assign obs_cnt  = obsCnt_q;
  assign busy     = (state_q != IDLE);

  prm_mask_accum #(
    .NUM_EDGE (NUM_EDGE),
    .OUT_W    (OUT_W),
    .NWORD    (NWORD),
    .IDX_W    (IDX_W)
  ) uAccum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush || (resFire && lastWord)),
    .load_i (sampleNow && !flush),
    .mask_i (chk_mask),
    .idx_i  (idx_q),
    .free_o (res_data)
  );

  // Scheduler: accept a code, let the checker array settle for CHK_LAT
  // cycles, fold its mask in, and after the frame's last code walk the
  // result words. Flush abandons the frame but keeps chk_code, since the
  // checker array is don't-care outside WAIT anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      chkCode_q <= '0;
      last_q    <= 1'b0;
      wCnt_q    <= 4'd0;
      idx_q     <= '0;
      obsCnt_q  <= 16'd0;
    end else if (flush) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      obsCnt_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (obsFire) begin
            chkCode_q <= obs_code;
            last_q    <= obs_last;
            wCnt_q    <= 4'(CHK_LAT - 1);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (wCnt_q == 4'd0) begin
            obsCnt_q <= obsCnt_d;
            idx_q    <= '0;
            state_q  <= last_q ? DRAIN : IDLE;
          end else begin
            wCnt_q <= wCnt_q - 4'd1;
          end
        end
        DRAIN: begin
          if (resFire) begin
            if (lastWord) begin
              idx_q    <= '0;
              obsCnt_q <= 16'd0;
              state_q  <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Directed bench for prm_edge_chk_sched. Three instances: A (64 edges,
// CHK_LAT=1), B (40 edges, shares A's stimulus so its padded word can be
// checked) and C (64 edges, CHK_LAT=3) with its own stimulus.
module tb_prm_edge_chk_sched;

  logic clk = 1'b0;
  logic rst;

  logic        flush;
  logic        obsValid;
  logic [14:0] obsCode;
  logic        obsLast;
  logic [63:0] chkMask;
  logic        resReady;

  logic        aObsReady, aResValid, aResLast, aBusy;
  logic [14:0] aChkCode;
  logic [31:0] aResData;
  logic [0:0]  aResIdx;
  logic [15:0] aObsCnt;

  logic        bObsReady, bResValid, bResLast, bBusy;
  logic [14:0] bChkCode;
  logic [31:0] bResData;
  logic [0:0]  bResIdx;
  logic [15:0] bObsCnt;

  logic        cFlush, cValid, cLast, cResReady;
  logic [14:0] cCode;
  logic [63:0] cMask;
  logic        cObsReady, cResValid, cResLast, cBusy;
  logic [14:0] cChkCode;
  logic [31:0] cResData;
  logic [0:0]  cResIdx;
  logic [15:0] cObsCnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] wA [2];
  logic [31:0] wB [2];
  logic        lA [2];
  logic [0:0]  iA [2];
  logic [15:0] cntA;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  prm_edge_chk_sched #(.NUM_EDGE(64), .CODE_W(15), .CHK_LAT(1), .OUT_W(32)) dutA (
    .clk(clk), .rst(rst), .flush(flush), .obs_valid(obsValid), .obs_ready(aObsReady),
    .obs_code(obsCode), .obs_last(obsLast), .chk_code(aChkCode), .chk_mask(chkMask),
    .res_valid(aResValid), .res_ready(resReady), .res_data(aResData), .res_idx(aResIdx),
    .res_last(aResLast), .obs_cnt(aObsCnt), .busy(aBusy)
  );

  prm_edge_chk_sched #(.NUM_EDGE(40), .CODE_W(15), .CHK_LAT(1), .OUT_W(32)) dutB (
    .clk(clk), .rst(rst), .flush(flush), .obs_valid(obsValid), .obs_ready(bObsReady),
    .obs_code(obsCode), .obs_last(obsLast), .chk_code(bChkCode), .chk_mask(chkMask[39:0]),
    .res_valid(bResValid), .res_ready(resReady), .res_data(bResData), .res_idx(bResIdx),
    .res_last(bResLast), .obs_cnt(bObsCnt), .busy(bBusy)
  );

  prm_edge_chk_sched #(.NUM_EDGE(64), .CODE_W(15), .CHK_LAT(3), .OUT_W(32)) dutC (
    .clk(clk), .rst(rst), .flush(cFlush), .obs_valid(cValid), .obs_ready(cObsReady),
    .obs_code(cCode), .obs_last(cLast), .chk_code(cChkCode), .chk_mask(cMask),
    .res_valid(cResValid), .res_ready(cResReady), .res_data(cResData), .res_idx(cResIdx),
    .res_last(cResLast), .obs_cnt(cObsCnt), .busy(cBusy)
  );

  // Offer one code to A/B, hold its mask through the single settle cycle
  task automatic applyStimulus(input logic [14:0] code, input logic lst, input logic [63:0] mask);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!aObsReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (aObsReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL obs_ready_timeout got=%b exp=1", aObsReady);
    end
    obsValid = 1'b1;
    obsCode  = code;
    obsLast  = lst;
    chkMask  = mask;
    @(posedge clk);
    #1 obsValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Collect both result words of A and B with the planner always ready
  task automatic drainFrame();
    int guard;
    resReady = 1'b1;
    for (int w = 0; w < 2; w++) begin
      guard = 0;
      @(negedge clk);
      while (!aResValid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (aResValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL res_valid_timeout word=%0d got=%b exp=1", w, aResValid);
      end
      wA[w] = aResData;
      wB[w] = bResData;
      lA[w] = aResLast;
      iA[w] = aResIdx;
      cntA  = aObsCnt;
      @(posedge clk);
      #1;
    end
    resReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (aObsReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_obs_ready got=%b exp=0", aObsReady); end
    checks++;
    if (aResValid !== 1'b0 || aBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid_busy got=%b%b exp=00", aResValid, aBusy);
    end
    checks++;
    if (aChkCode !== 15'h0 || aObsCnt !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_code_cnt got=%h/%h exp=0/0", aChkCode, aObsCnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (aObsReady !== 1'b1) begin errors++; $display("[TB] FAIL idle_obs_ready got=%b exp=1", aObsReady); end
  endtask

  task automatic test_single_code();
    applyStimulus(15'h7FFF, 1'b1, 64'h0000_0000_0000_0001);
    checks++;
    if (aChkCode !== 15'h7FFF) begin errors++; $display("[TB] FAIL single_chk_code got=%h exp=7fff", aChkCode); end
    drainFrame();
    checks++;
    if (wA[0] !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL single_word0 got=%h exp=fffffffe", wA[0]); end
    checks++;
    if (wA[1] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL single_word1 got=%h exp=ffffffff", wA[1]); end
    checks++;
    if (iA[0] !== 1'b0 || iA[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL single_idx got=%b%b exp=01", iA[0], iA[1]);
    end
    checks++;
    if (lA[0] !== 1'b0 || lA[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL single_last got=%b%b exp=01", lA[0], lA[1]);
    end
    checks++;
    if (cntA !== 16'd1) begin errors++; $display("[TB] FAIL single_obs_cnt got=%0d exp=1", cntA); end
    checks++;
    if (aBusy !== 1'b0 || aObsCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL single_after got=%b/%0d exp=0/0", aBusy, aObsCnt);
    end
  endtask

  task automatic test_multi_code();
    applyStimulus(15'h0001, 1'b0, 64'h0000_0000_0000_0001);
    applyStimulus(15'h0002, 1'b0, 64'h0000_0000_0000_0100);
    applyStimulus(15'h0003, 1'b1, 64'h8000_0000_0000_0000);
    drainFrame();
    checks++;
    if (wA[0] !== 32'hFFFF_FEFE) begin errors++; $display("[TB] FAIL multi_word0 got=%h exp=fffffefe", wA[0]); end
    checks++;
    if (wA[1] !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL multi_word1 got=%h exp=7fffffff", wA[1]); end
    checks++;
    if (cntA !== 16'd3) begin errors++; $display("[TB] FAIL multi_obs_cnt got=%0d exp=3", cntA); end
  endtask

  task automatic test_padding();
    applyStimulus(15'h0000, 1'b1, 64'h0);
    drainFrame();
    checks++;
    if (wB[0] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL pad_word0 got=%h exp=ffffffff", wB[0]); end
    checks++;
    if (wB[1] !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL pad_word1 got=%h exp=000000ff", wB[1]); end
    checks++;
    if (wA[1] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL nopad_word1 got=%h exp=ffffffff", wA[1]); end
  endtask

  task automatic test_chk_latency();
    int lowCnt;
    lowCnt = 0;
    @(negedge clk);
    cValid = 1'b1; cCode = 15'h1234; cLast = 1'b0; cMask = 64'h1;
    checks++;
    if (cObsReady !== 1'b1) begin errors++; $display("[TB] FAIL lat_ready_idle got=%b exp=1", cObsReady); end
    @(posedge clk);
    #1 cValid = 1'b0; cMask = 64'hF0;
    checks++;
    if (cChkCode !== 15'h1234) begin errors++; $display("[TB] FAIL lat_chk_code got=%h exp=1234", cChkCode); end
    @(negedge clk);
    if (!cObsReady) lowCnt++;
    @(posedge clk);
    #1 cMask = 64'hFF00;
    @(negedge clk);
    if (!cObsReady) lowCnt++;
    @(posedge clk);
    #1 cMask = 64'h4;
    @(negedge clk);
    if (!cObsReady) lowCnt++;
    @(posedge clk);
    #1 cMask = 64'h0;
    @(negedge clk);
    checks++;
    if (cObsReady !== 1'b1) begin errors++; $display("[TB] FAIL lat_ready_back got=%b exp=1", cObsReady); end
    checks++;
    if (lowCnt !== 3) begin errors++; $display("[TB] FAIL lat_ready_low got=%0d exp=3", lowCnt); end
    checks++;
    if (cObsCnt !== 16'd1) begin errors++; $display("[TB] FAIL lat_obs_cnt got=%0d exp=1", cObsCnt); end
    cValid = 1'b1; cCode = 15'h0042; cLast = 1'b1;
    @(posedge clk);
    #1 cValid = 1'b0;
    repeat (3) @(posedge clk);
    cResReady = 1'b1;
    @(negedge clk);
    checks++;
    if (cResValid !== 1'b1 || cResData !== 32'hFFFF_FFFB || cResIdx !== 1'b0) begin
      errors++; $display("[TB] FAIL lat_word0 got=%b/%h/%b exp=1/fffffffb/0", cResValid, cResData, cResIdx);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (cResValid !== 1'b1 || cResData !== 32'hFFFF_FFFF || cResLast !== 1'b1) begin
      errors++; $display("[TB] FAIL lat_word1 got=%b/%h/%b exp=1/ffffffff/1", cResValid, cResData, cResLast);
    end
    @(posedge clk);
    #1 cResReady = 1'b0;
    checks++;
    if (cBusy !== 1'b0) begin errors++; $display("[TB] FAIL lat_done_busy got=%b exp=0", cBusy); end
  endtask

  task automatic test_flush();
    applyStimulus(15'h0000, 1'b1, 64'h5);
    resReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (aResValid !== 1'b1 || aResData !== 32'hFFFF_FFFA || aResIdx !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_word cyc=%0d got=%b/%h/%b exp=1/fffffffa/0", k, aResValid, aResData, aResIdx);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++;
    if (aResValid !== 1'b0 || aBusy !== 1'b0 || aObsCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL flush_drain got=%b/%b/%0d exp=0/0/0", aResValid, aBusy, aObsCnt);
    end
    @(negedge clk);
    flush = 1'b1; obsValid = 1'b1; obsCode = 15'h0055; obsLast = 1'b1;
    #1;
    checks++;
    if (aObsReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got=%b exp=0", aObsReady); end
    @(posedge clk);
    #1 flush = 1'b0; obsValid = 1'b0;
    checks++;
    if (aBusy !== 1'b0 || aChkCode !== 15'h0000) begin
      errors++; $display("[TB] FAIL flush_no_accept got=%b/%h exp=0/0000", aBusy, aChkCode);
    end
    applyStimulus(15'h0001, 1'b1, 64'h0);
    drainFrame();
    checks++;
    if (wA[0] !== 32'hFFFF_FFFF || wA[1] !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL flush_clean got=%h_%h exp=ffffffff_ffffffff", wA[1], wA[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    applyStimulus(15'h0011, 1'b0, 64'h1);
    checks++;
    if (aObsCnt !== 16'd1) begin errors++; $display("[TB] FAIL mid_cnt_before got=%0d exp=1", aObsCnt); end
    @(negedge clk);
    obsValid = 1'b1; obsCode = 15'h0022; obsLast = 1'b1; chkMask = 64'h2;
    @(posedge clk);
    #1 obsValid = 1'b0;
    checks++;
    if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_wait got=%b exp=1", aBusy); end
    rst = 1'b1;
    #1;
    checks++;
    if (aBusy !== 1'b0 || aObsCnt !== 16'd0 || aChkCode !== 15'h0 || aResValid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got=%b/%0d/%h/%b exp=0/0/0000/0", aBusy, aObsCnt, aChkCode, aResValid);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(15'h0033, 1'b1, 64'h0000_0000_8000_0000);
    drainFrame();
    checks++;
    if (wA[0] !== 32'h7FFF_FFFF || wA[1] !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL mid_fresh got=%h_%h exp=ffffffff_7fffffff", wA[1], wA[0]);
    end
    checks++;
    if (cntA !== 16'd1) begin errors++; $display("[TB] FAIL mid_fresh_cnt got=%0d exp=1", cntA); end
  endtask

  // Hard stop in case something upstream wedges the simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    flush = 1'b0; obsValid = 1'b0; obsCode = '0; obsLast = 1'b0; chkMask = '0; resReady = 1'b0;
    cFlush = 1'b0; cValid = 1'b0; cCode = '0; cLast = 1'b0; cMask = '0; cResReady = 1'b0;
    test_reset();
    test_single_code();
    test_multi_code();
    test_padding();
    test_chk_latency();
    test_flush();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
